// File: rtl/mtm_alu_core_ctrl.sv
// Sequencer between the frame deserializer and the ALU core.
// Latency with the block idle: in_valid at cycle 0, alu_start at 2, out_valid one cycle after alu_done.
// Backpressure: out_ready stalls only the output stage; the input side never stalls, so extra inputs are dropped and overrun is set.
//
// Ports:
//   clk, rst             clock and synchronous active-low reset
//   in_valid/in_A/in_B/in_op, in_err/in_err_frame   command and error-frame pulses from the deserializer
//   alu_start/alu_A/alu_B/alu_op, alu_done/alu_C/alu_flags   ALU core launch and result
//   out_valid/out_ready/out_is_err/out_C/out_flags/out_ctl   result or error frame to the serializer
//   busy, overrun, timeout   status; overrun and timeout are sticky until reset
// Build option: MTM_CTRL_QUEUE2_EN widens the input slot to a 2-entry FIFO.
module mtm_alu_core_ctrl #(
    parameter int unsigned TIMEOUT_CYC   = 64,
    parameter logic [7:0]  TIMEOUT_FRAME = 8'h87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [2:0]  in_op,
    input  logic        in_err,
    input  logic [7:0]  in_err_frame,
    output logic        alu_start,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic        alu_done,
    input  logic [31:0] alu_C,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    output logic        out_is_err,
    output logic [31:0] out_C,
    output logic [3:0]  out_flags,
    output logic [7:0]  out_ctl,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    typedef struct packed {
        logic        is_err;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [7:0]  frame;
    } entry_t;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ALU, SEND, SEND_ERR} state_t;

`ifdef MTM_CTRL_QUEUE2_EN
    localparam logic [1:0] QDEPTH = 2'd2;
`else
    localparam logic [1:0] QDEPTH = 2'd1;
`endif

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    entry_t     q0;           // head of the input queue
`ifdef MTM_CTRL_QUEUE2_EN
    entry_t     q1;
`endif
    logic [1:0] q_cnt;
    logic [7:0] wait_cnt;

    logic   pop;
    logic   full;
    logic   push;
    entry_t in_entry;

    // An error pulse wins over a simultaneous command; the command is
    // discarded silently, so it does not count as an overrun.
    always_comb begin
        pop             = (state == IDLE) && (q_cnt != 2'd0);
        full            = (q_cnt == QDEPTH) && !pop;
        push            = (in_valid || in_err) && !full;
        in_entry.is_err = in_err;
        in_entry.a      = in_A;
        in_entry.b      = in_B;
        in_entry.op     = in_op;
        in_entry.frame  = in_err_frame;
    end

    assign busy = (state != IDLE) || (q_cnt != 2'd0);

    // Input queue: shift-down FIFO, head always in q0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q0      <= '0;
`ifdef MTM_CTRL_QUEUE2_EN
            q1      <= '0;
`endif
            q_cnt   <= 2'd0;
            overrun <= 1'b0;
        end else begin
`ifdef MTM_CTRL_QUEUE2_EN
            if (pop) begin
                q0 <= q1;
            end
            // Write slot is the occupancy after this cycle's pop.
            if (push) begin
                if (q_cnt == 2'd2 || (q_cnt == 2'd1 && !pop)) begin
                    q1 <= in_entry;
                end else begin
                    q0 <= in_entry;
                end
            end
`else
            if (push) begin
                q0 <= in_entry;
            end
`endif
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
            if ((in_valid || in_err) && full) begin
                overrun <= 1'b1;
            end
        end
    end

    // Control FSM, all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            alu_start  <= 1'b0;
            alu_A      <= 32'd0;
            alu_B      <= 32'd0;
            alu_op     <= 3'd0;
            out_valid  <= 1'b0;
            out_is_err <= 1'b0;
            out_C      <= 32'd0;
            out_flags  <= 4'd0;
            out_ctl    <= 8'd0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (q0.is_err) begin
                            out_ctl    <= q0.frame;
                            out_is_err <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= SEND_ERR;
                        end else begin
                            alu_A     <= q0.a;
                            alu_B     <= q0.b;
                            alu_op    <= q0.op;
                            alu_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    alu_start <= 1'b0;
                    wait_cnt  <= 8'd0;
                    state     <= WAIT_ALU;
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        out_C      <= alu_C;
                        out_flags  <= alu_flags;
                        out_is_err <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= SEND;
                    end else if (wait_cnt == TO_LAST) begin
                        out_ctl    <= TIMEOUT_FRAME;
                        timeout    <= 1'b1;
                        out_is_err <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= SEND_ERR;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                SEND, SEND_ERR: begin
                    // out_valid is always high here, so out_ready alone completes the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_core_ctrl.sv
// Directed bench for mtm_alu_core_ctrl: inputs change and outputs are checked on the falling edge.
// Cycle comments count falling edges from the edge where the stimulus of each step is applied (c0).
// Expectations for the queued build follow the MTM_CTRL_QUEUE2_EN macro.
module tb_mtm_alu_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_op;
    logic        in_err;
    logic [7:0]  in_err_frame;
    logic        alu_start;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [31:0] alu_C;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_is_err;
    logic [31:0] out_C;
    logic [3:0]  out_flags;
    logic [7:0]  out_ctl;
    logic        out_ready;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int n_chk  = 0;
    int n_pass = 0;

    mtm_alu_core_ctrl #(.TIMEOUT_CYC(64), .TIMEOUT_FRAME(8'h87)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_A(in_A), .in_B(in_B), .in_op(in_op),
        .in_err(in_err), .in_err_frame(in_err_frame),
        .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_done(alu_done), .alu_C(alu_C), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_is_err(out_is_err), .out_C(out_C),
        .out_flags(out_flags), .out_ctl(out_ctl), .out_ready(out_ready),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu_start"},  alu_start,  0);
        chk({tag, ".alu_A"},      alu_A,      0);
        chk({tag, ".alu_B"},      alu_B,      0);
        chk({tag, ".alu_op"},     alu_op,     0);
        chk({tag, ".out_valid"},  out_valid,  0);
        chk({tag, ".out_is_err"}, out_is_err, 0);
        chk({tag, ".out_C"},      out_C,      0);
        chk({tag, ".out_flags"},  out_flags,  0);
        chk({tag, ".out_ctl"},    out_ctl,    0);
        chk({tag, ".busy"},       busy,       0);
        chk({tag, ".overrun"},    overrun,    0);
        chk({tag, ".timeout"},    timeout,    0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_op = '0;
        in_err = 1'b0; in_err_frame = '0; alu_done = 1'b0; alu_C = '0;
        alu_flags = '0; out_ready = 1'b0;

        // Reset state
        cyc(2);
        chk_all_zero("reset");
        rst = 1'b1;
        cyc(1);

        // T1: single command 3 op 5, ALU answers 3 cycles after start
        in_valid = 1'b1; in_A = 32'h3; in_B = 32'h5; in_op = 3'b100;      // c0
        cyc(1); in_valid = 1'b0;                                            // c1
        chk("t1.start_c1", alu_start, 0);
        chk("t1.busy_c1", busy, 1);
        cyc(1);                                                             // c2
        chk("t1.start_c2", alu_start, 1);
        chk("t1.alu_A", alu_A, 32'h3);
        chk("t1.alu_B", alu_B, 32'h5);
        chk("t1.alu_op", alu_op, 3'b100);
        cyc(1);                                                             // c3
        chk("t1.start_c3", alu_start, 0);
        chk("t1.valid_c3", out_valid, 0);
        cyc(2);                                                             // c5
        alu_done = 1'b1; alu_C = 32'h8; alu_flags = 4'b0001;
        cyc(1); alu_done = 1'b0; alu_C = 32'hFFFF_FFFF; alu_flags = 4'hF;   // c6
        for (int i = 0; i < 4; i++) begin                                   // c6..c9
            chk($sformatf("t1.hold_valid_%0d", i), out_valid, 1);
            chk($sformatf("t1.hold_C_%0d", i), out_C, 32'h8);
            cyc(1);
        end
        chk("t1.valid_c10", out_valid, 1);                                  // c10
        chk("t1.is_err", out_is_err, 0);
        chk("t1.flags", out_flags, 4'b0001);
        chk("t1.overrun", overrun, 0);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c11
        chk("t1.valid_after_acc", out_valid, 0);
        cyc(1);                                                             // c12
        chk("t1.busy_end", busy, 0);

        // T2: error frame C9 goes straight out, no ALU launch
        in_err = 1'b1; in_err_frame = 8'hC9;                                // c0
        cyc(1); in_err = 1'b0;                                              // c1
        chk("t2.start_c1", alu_start, 0);
        cyc(1);                                                             // c2
        chk("t2.start_c2", alu_start, 0);
        chk("t2.valid", out_valid, 1);
        chk("t2.is_err", out_is_err, 1);
        chk("t2.ctl", out_ctl, 8'hC9);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c3
        chk("t2.valid_after_acc", out_valid, 0);
        cyc(1);

        // T5: command and error in the same cycle, only the error survives
        in_valid = 1'b1; in_A = 32'h55; in_err = 1'b1; in_err_frame = 8'hA5; // c0
        cyc(1); in_valid = 1'b0; in_err = 1'b0;                             // c1
        chk("t5.start_c1", alu_start, 0);
        cyc(1);                                                             // c2
        chk("t5.start_c2", alu_start, 0);
        chk("t5.valid", out_valid, 1);
        chk("t5.is_err", out_is_err, 1);
        chk("t5.ctl", out_ctl, 8'hA5);
        chk("t5.overrun", overrun, 0);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c3
        chk("t5.valid_after_acc", out_valid, 0);
        chk("t5.busy_c3", busy, 0);
        cyc(1);                                                             // c4
        chk("t5.start_c4", alu_start, 0);

        // T3: ALU never answers, timeout after 64 cycles in WAIT_ALU
        in_valid = 1'b1; in_A = 32'h9; in_B = 32'h1; in_op = 3'b000;       // c0
        cyc(1); in_valid = 1'b0;                                            // c1
        cyc(1);                                                             // c2
        chk("t3.start", alu_start, 1);
        cyc(64);                                                            // c66
        chk("t3.valid_c66", out_valid, 0);
        chk("t3.timeout_c66", timeout, 0);
        cyc(1);                                                             // c67
        chk("t3.valid_c67", out_valid, 1);
        chk("t3.is_err", out_is_err, 1);
        chk("t3.ctl", out_ctl, 8'h87);
        chk("t3.timeout_c67", timeout, 1);
        alu_done = 1'b1; alu_C = 32'hDEAD;
        cyc(1); alu_done = 1'b0;                                            // c68
        chk("t3.valid_c68", out_valid, 1);
        chk("t3.ctl_c68", out_ctl, 8'h87);
        chk("t3.late_done_C", out_C, 32'h8);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c69
        chk("t3.valid_after_acc", out_valid, 0);
        cyc(3);                                                             // c72
        chk("t3.valid_c72", out_valid, 0);
        chk("t3.busy_c72", busy, 0);
        chk("t3.timeout_sticky", timeout, 1);

        // T4: three commands while the ALU is busy
        in_valid = 1'b1; in_A = 32'h1;                                      // c0
        cyc(1); in_valid = 1'b0;                                            // c1
        cyc(2);                                                             // c3
        chk("t4.overrun_c3", overrun, 0);
        in_valid = 1'b1; in_A = 32'h2;
        cyc(1); in_A = 32'h3;                                               // c4
        cyc(1); in_valid = 1'b0;                                            // c5
`ifdef MTM_CTRL_QUEUE2_EN
        chk("t4.overrun_c5", overrun, 0);
`else
        chk("t4.overrun_c5", overrun, 1);
`endif
        cyc(1);                                                             // c6
        alu_done = 1'b1; alu_C = 32'h11;
        cyc(1); alu_done = 1'b0;                                            // c7
        chk("t4.valid1", out_valid, 1);
        chk("t4.C1", out_C, 32'h11);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c8
        chk("t4.valid_c8", out_valid, 0);
        cyc(1);                                                             // c9
        chk("t4.start2", alu_start, 1);
        chk("t4.A2", alu_A, 32'h2);
        cyc(1);                                                             // c10
        alu_done = 1'b1; alu_C = 32'h22;
        cyc(1); alu_done = 1'b0;                                            // c11
        chk("t4.valid2", out_valid, 1);
        chk("t4.C2", out_C, 32'h22);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c12
`ifdef MTM_CTRL_QUEUE2_EN
        chk("t4.busy_c12", busy, 1);
        cyc(1);                                                             // c13
        chk("t4.start3", alu_start, 1);
        chk("t4.A3", alu_A, 32'h3);
        cyc(1);                                                             // c14
        alu_done = 1'b1; alu_C = 32'h33;
        cyc(1); alu_done = 1'b0;                                            // c15
        chk("t4.C3", out_C, 32'h33);
        out_ready = 1'b1;
        cyc(1); out_ready = 1'b0;                                           // c16
        chk("t4.busy_end", busy, 0);
        chk("t4.overrun_end", overrun, 0);
`else
        chk("t4.busy_c12", busy, 0);
        cyc(1);                                                             // c13
        chk("t4.no_start3", alu_start, 0);
        chk("t4.overrun_end", overrun, 1);
`endif
        cyc(1);

        // T6: reset during WAIT_ALU, later alu_done ignored
        in_valid = 1'b1; in_A = 32'h44; in_B = 32'h4; in_op = 3'b001;      // c0
        cyc(1); in_valid = 1'b0;                                            // c1
        cyc(1);                                                             // c2
        chk("t6.start", alu_start, 1);
        cyc(2); rst = 1'b0;                                                 // c4
        cyc(1);                                                             // c5
        chk_all_zero("t6.reset");
        rst = 1'b1;
        cyc(1);                                                             // c6
        alu_done = 1'b1; alu_C = 32'h77;
        cyc(1); alu_done = 1'b0;                                            // c7
        for (int i = 0; i < 3; i++) begin                                   // c7..c9
            chk($sformatf("t6.no_valid_%0d", i), out_valid, 0);
            cyc(1);
        end
        chk("t6.busy_end", busy, 0);
        chk("t6.C_end", out_C, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mtm_alu_core_ctrl.md
Name: mtm_alu_core_ctrl

Overview:
Sequencer between the serial-frame deserializer and the ALU core.
- Accepts decoded commands (A, B, OP) and error control frames from the deserializer as single-cycle pulses and buffers them.
- Launches the ALU core with a start pulse and waits for its done strobe, guarded by a timeout.
- Hands each result or error frame to the serializer over a valid/ready handshake.
- Keeps the deserializer free-running: it has no backpressure, so overruns are counted and flagged.

Parameters:
TIMEOUT_CYC, 64, cycles allowed in WAIT_ALU before the command is abandoned (2..255)
TIMEOUT_FRAME, 8'h87, control frame emitted on ALU timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  one-cycle pulse, new command on in_A/in_B/in_op
in_A  in  32  operand A
in_B  in  32  operand B
in_op  in  3  opcode
in_err  in  1  one-cycle pulse, deserializer detected a frame error
in_err_frame  in  8  control frame paired with in_err
alu_start  out  1  one-cycle launch pulse to the ALU core
alu_A  out  32  operand A to the ALU, held stable until alu_done
alu_B  out  32  operand B to the ALU, held stable until alu_done
alu_op  out  3  opcode to the ALU, held stable until alu_done
alu_done  in  1  ALU result valid strobe
alu_C  in  32  ALU result
alu_flags  in  4  ALU flags (carry, overflow, zero, negative)
out_valid  out  1  result or error frame available to the serializer
out_is_err  out  1  1 = out_ctl is meaningful, 0 = out_C/out_flags are meaningful
out_C  out  32  result word
out_flags  out  4  result flags
out_ctl  out  8  error control frame
out_ready  in  1  serializer accepts the current output
busy  out  1  FSM not in IDLE, or a command slot is occupied
overrun  out  1  sticky: an input was dropped
timeout  out  1  sticky: an ALU timeout occurred

Behaviour:
Reset
- On reset every output is 0; the slot is cleared and the FSM goes to IDLE.
- A reset asserted mid-operation aborts the command; a later alu_done is ignored.

Input slot (one entry)
- A tagged entry holds either {A, B, OP} or {err_frame}.
- Loaded on in_valid or in_err when the slot is empty. The slot frees in the same cycle the FSM pops it, so pop and load may coincide.
- Input while the slot is full and not popping: input dropped, overrun <= 1.
- in_err and in_valid in the same cycle: the error entry is stored, the command is discarded, overrun is unchanged.

FSM states: IDLE, LAUNCH, WAIT_ALU, SEND, SEND_ERR.
- IDLE: if the slot is valid, pop it. Command entry → LAUNCH and register alu_A/alu_B/alu_op. Error entry → SEND_ERR with out_ctl = frame.
- LAUNCH: alu_start = 1 for exactly this cycle; clear the timeout counter; → WAIT_ALU.
- WAIT_ALU:
  - alu_done = 1: capture alu_C and alu_flags → SEND.
  - Otherwise increment the counter. When the counter equals TIMEOUT_CYC-1 without done: out_ctl = TIMEOUT_FRAME, timeout <= 1 → SEND_ERR.
  - alu_done seen in any other state is ignored.
- SEND: out_valid = 1, out_is_err = 0; out_C/out_flags stable. If out_valid && out_ready: clear out_valid → IDLE.
- SEND_ERR: out_valid = 1, out_is_err = 1; same handshake as SEND.

Latency and handshake rules
- Latency with the block idle: in_valid at cycle 0 → slot at 1 → LAUNCH at 2 (alu_start) → alu_done at cycle N → out_valid at N+1.
- out_valid never drops before acceptance, and the output fields do not change while out_valid is high.
- out_ready is ignored while out_valid = 0.
- Back-to-back acceptance: a buffered command reaches LAUNCH two cycles after the handshake.
- The timeout counter is 8 bits and saturates; no wrap-around is allowed.
- The sticky flags clear only on reset.

Optional Feature:
MTM_CTRL_QUEUE2_EN
- Defined: the slot becomes a 2-entry FIFO with order preserved. overrun is set only when both entries are full and there is no pop. A simultaneous push and pop on a full FIFO is accepted.
- Undefined: the single-entry slot described above.

Test Plan:
- Single command A=32'h0000_0003, B=32'h0000_0005, op=3'b100 → alu_start at cycle 2; ALU returns C=8 after 3 cycles → out_valid, out_C=32'h8, out_is_err=0; held for 4 cycles with out_ready=0, accepted on the 5th.
- in_err with frame 8'hC9 → out_valid with out_is_err=1, out_ctl=8'hC9; no alu_start.
- alu_done never asserted → after TIMEOUT_CYC=64 cycles in WAIT_ALU, out_ctl=8'h87 and timeout=1; a late alu_done is ignored.
- Three in_valid pulses while the ALU is busy → first runs, second is buffered, third dropped with overrun=1. With MTM_CTRL_QUEUE2_EN the third is kept and overrun stays 0.
- in_valid and in_err in the same cycle → only the error frame is output, overrun=0.
- rst low during WAIT_ALU → all outputs 0, FSM in IDLE; a following alu_done produces no out_valid.
